// File: rtl/decode_stage.sv
// MIPS R2000 instruction-decode stage: decode, regfile read, branch/jump
// resolution, hazard stall with replay hold register, and the ID/EX buffer.
module decode_stage #(
  parameter int WIDTH    = 32,
  parameter int REG_ADDR = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    pc_in,
  input  logic [WIDTH-1:0]    instruction_in,
  output logic [REG_ADDR-1:0] rf_rs_addr,
  output logic [REG_ADDR-1:0] rf_rt_addr,
  input  logic [WIDTH-1:0]    rf_rs_data,
  input  logic [WIDTH-1:0]    rf_rt_data,
  input  logic                ex_fwd_reg_write,
  input  logic                ex_fwd_mem_read,
  input  logic [REG_ADDR-1:0] ex_fwd_dest,
  input  logic                mem_fwd_reg_write,
  input  logic                mem_fwd_mem_read,
  input  logic [REG_ADDR-1:0] mem_fwd_dest,
  input  logic [WIDTH-1:0]    mem_fwd_result,
  output logic                stall,
  output logic                branch_taken,
  output logic [WIDTH-1:0]    branch_target,
  output logic                illegal,
  output logic [WIDTH-1:0]    ex_pc,
  output logic [WIDTH-1:0]    ex_rs_data,
  output logic [WIDTH-1:0]    ex_rt_data,
  output logic [WIDTH-1:0]    ex_imm,
  output logic [4:0]          ex_shamt,
  output logic [REG_ADDR-1:0] ex_dest,
  output logic [3:0]          ex_alu_op,
  output logic                ex_alu_src_imm,
  output logic                ex_reg_write,
  output logic                ex_mem_read,
  output logic                ex_mem_write,
  output logic                ex_link
);

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
    ALU_XOR = 4'd4, ALU_NOR = 4'd5, ALU_SLT = 4'd6, ALU_SLTU = 4'd7,
    ALU_SLL = 4'd8, ALU_SRL = 4'd9, ALU_SRA = 4'd10, ALU_LUI = 4'd11
  } alu_op_e;

  logic                hold_valid_q;
  logic [WIDTH-1:0]    hold_pc_q, hold_instr_q;
  logic [WIDTH-1:0]    cur_pc, cur_instr;

  assign cur_pc    = hold_valid_q ? hold_pc_q    : pc_in;
  assign cur_instr = hold_valid_q ? hold_instr_q : instruction_in;

  logic [5:0]          opcode, funct;
  logic [REG_ADDR-1:0] rs, rt, rd;
  logic [15:0]         imm16;
  logic [25:0]         instr_index;

  assign opcode      = cur_instr[31:26];
  assign rs          = cur_instr[25:21];
  assign rt          = cur_instr[20:16];
  assign rd          = cur_instr[15:11];
  assign funct       = cur_instr[5:0];
  assign imm16       = cur_instr[15:0];
  assign instr_index = cur_instr[25:0];
  assign rf_rs_addr  = rs;
  assign rf_rt_addr  = rt;

  logic                supported, src_imm, reg_wr, mem_rd, mem_wr, zext;
  logic                uses_rs, uses_rt, is_beq, is_bne, is_j, is_jal, is_jr;
  logic [REG_ADDR-1:0] dest;
  alu_op_e             alu_op;

  // NOTE: every output gets a default first so no path leaves one unassigned
  // and infers a latch.
  always_comb begin
    supported = 1'b0; src_imm = 1'b0; reg_wr = 1'b0; mem_rd = 1'b0;
    mem_wr = 1'b0; zext = 1'b0; uses_rs = 1'b0; uses_rt = 1'b0;
    is_beq = 1'b0; is_bne = 1'b0; is_j = 1'b0; is_jal = 1'b0; is_jr = 1'b0;
    dest = '0; alu_op = ALU_ADD;
    if (opcode == 6'h00) begin
      supported = 1'b1; reg_wr = 1'b1; dest = rd; uses_rs = 1'b1; uses_rt = 1'b1;
      unique case (funct)
        6'h20, 6'h21: alu_op = ALU_ADD;
        6'h22, 6'h23: alu_op = ALU_SUB;
        6'h24: alu_op = ALU_AND;
        6'h25: alu_op = ALU_OR;
        6'h26: alu_op = ALU_XOR;
        6'h27: alu_op = ALU_NOR;
        6'h2A: alu_op = ALU_SLT;
        6'h2B: alu_op = ALU_SLTU;
        6'h00: begin alu_op = ALU_SLL; uses_rs = 1'b0; end
        6'h02: begin alu_op = ALU_SRL; uses_rs = 1'b0; end
        6'h03: begin alu_op = ALU_SRA; uses_rs = 1'b0; end
        6'h08: begin is_jr = 1'b1; reg_wr = 1'b0; dest = '0; uses_rt = 1'b0; end
        default: begin
          supported = 1'b0; reg_wr = 1'b0; dest = '0; uses_rs = 1'b0; uses_rt = 1'b0;
        end
      endcase
    end else begin
      // I-type ALU defaults; memory, branch and jump opcodes override below
      supported = 1'b1; src_imm = 1'b1; reg_wr = 1'b1; dest = rt; uses_rs = 1'b1;
      unique case (opcode)
        6'h08, 6'h09: alu_op = ALU_ADD;
        6'h0A: alu_op = ALU_SLT;
        6'h0B: alu_op = ALU_SLTU;
        6'h0C: begin alu_op = ALU_AND; zext = 1'b1; end
        6'h0D: begin alu_op = ALU_OR;  zext = 1'b1; end
        6'h0E: begin alu_op = ALU_XOR; zext = 1'b1; end
        6'h0F: alu_op = ALU_LUI;
        6'h23: mem_rd = 1'b1;
        6'h2B: begin mem_wr = 1'b1; reg_wr = 1'b0; dest = '0; uses_rt = 1'b1; end
        6'h04, 6'h05: begin
          is_beq = (opcode == 6'h04); is_bne = (opcode == 6'h05);
          src_imm = 1'b0; reg_wr = 1'b0; dest = '0; uses_rt = 1'b1;
        end
        6'h02: begin is_j = 1'b1; src_imm = 1'b0; reg_wr = 1'b0; dest = '0; uses_rs = 1'b0; end
        6'h03: begin
          is_jal = 1'b1; src_imm = 1'b0; dest = REG_ADDR'(31); uses_rs = 1'b0;
        end
        default: begin
          supported = 1'b0; src_imm = 1'b0; reg_wr = 1'b0; dest = '0; uses_rs = 1'b0;
        end
      endcase
    end
  end

  // Hazard detection: load-use for any operand, plus branch/JR operands that
  // are not yet available for the decode-stage comparator.
  logic br_rs, br_rt, load_use, ex_br_hit, mem_br_hit, stall_w;
  assign br_rs      = is_beq | is_bne | is_jr;
  assign br_rt      = is_beq | is_bne;
  assign load_use   = ex_fwd_mem_read && (ex_fwd_dest != '0) &&
                      ((uses_rs && ex_fwd_dest == rs) || (uses_rt && ex_fwd_dest == rt));
  assign ex_br_hit  = (ex_fwd_dest != '0) &&
                      ((br_rs && ex_fwd_dest == rs) || (br_rt && ex_fwd_dest == rt));
  assign mem_br_hit = (mem_fwd_dest != '0) &&
                      ((br_rs && mem_fwd_dest == rs) || (br_rt && mem_fwd_dest == rt));
  assign stall_w    = !rst && (load_use || (ex_fwd_reg_write && ex_br_hit) ||
                                (mem_fwd_mem_read && mem_br_hit));

  logic             mem_ok;
  logic [WIDTH-1:0] rs_op, rt_op, pc_plus4, br_off, target;
  assign mem_ok   = mem_fwd_reg_write && !mem_fwd_mem_read && (mem_fwd_dest != '0);
  assign rs_op    = (mem_ok && mem_fwd_dest == rs) ? mem_fwd_result : rf_rs_data;
  assign rt_op    = (mem_ok && mem_fwd_dest == rt) ? mem_fwd_result : rf_rt_data;
  assign pc_plus4 = cur_pc + WIDTH'(4);
  assign br_off   = {{(WIDTH-18){imm16[15]}}, imm16, 2'b00};

  always_comb begin
    target = pc_plus4 + br_off;
    if (is_j || is_jal) target = {pc_plus4[WIDTH-1 -: WIDTH-28], instr_index, 2'b00};
    else if (is_jr)     target = rs_op;
  end

  assign stall         = stall_w;
  assign branch_taken  = !rst && !stall_w &&
                         ((is_beq && rs_op == rt_op) || (is_bne && rs_op != rt_op) ||
                          is_j || is_jal || is_jr);
  assign branch_target = branch_taken ? target : '0;
  assign illegal       = !rst && !supported && !stall_w;

  logic                bubble;
  logic [REG_ADDR-1:0] dest_d;
  logic [3:0]          alu_op_d;
  logic                src_imm_d, reg_write_d, mem_read_d, mem_write_d, link_d;
  assign bubble      = stall_w || !supported || is_beq || is_bne || is_j || is_jr;
  assign dest_d      = bubble ? '0 : dest;
  assign alu_op_d    = bubble ? 4'd0 : alu_op;
  assign src_imm_d   = !bubble && src_imm;
  assign reg_write_d = !bubble && reg_wr && (dest != '0);
  assign mem_read_d  = !bubble && mem_rd;
  assign mem_write_d = !bubble && mem_wr;
  assign link_d      = !bubble && is_jal;

  // NOTE: non-blocking assignments for all state so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      ex_pc <= '0; ex_rs_data <= '0; ex_rt_data <= '0; ex_imm <= '0;
      ex_shamt <= '0; ex_dest <= '0; ex_alu_op <= '0; ex_alu_src_imm <= 1'b0;
      ex_reg_write <= 1'b0; ex_mem_read <= 1'b0; ex_mem_write <= 1'b0; ex_link <= 1'b0;
    end else begin
      hold_valid_q   <= stall_w;
      ex_pc          <= cur_pc;
      ex_rs_data     <= rf_rs_data;
      ex_rt_data     <= rf_rt_data;
      ex_imm         <= zext ? {{(WIDTH-16){1'b0}}, imm16} : {{(WIDTH-16){imm16[15]}}, imm16};
      ex_shamt       <= cur_instr[10:6];
      ex_dest        <= dest_d;
      ex_alu_op      <= alu_op_d;
      ex_alu_src_imm <= src_imm_d;
      ex_reg_write   <= reg_write_d;
      ex_mem_read    <= mem_read_d;
      ex_mem_write   <= mem_write_d;
      ex_link        <= link_d;
    end
  end

  // NOTE: the hold payload needs no reset; it is only observed while
  // hold_valid_q is set, and that flag is reset.
  always_ff @(posedge clk) begin
    if (stall_w) begin
      hold_pc_q    <= cur_pc;
      hold_instr_q <= cur_instr;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: combinational outputs checked in place,
// ID/EX contents checked through an expected-entry scoreboard.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in, instruction_in, rf_rs_data, rf_rt_data, mem_fwd_result;
  logic [4:0]  rf_rs_addr, rf_rt_addr, ex_fwd_dest, mem_fwd_dest;
  logic        ex_fwd_reg_write, ex_fwd_mem_read, mem_fwd_reg_write, mem_fwd_mem_read;
  logic        stall, branch_taken, illegal;
  logic [31:0] branch_target, ex_pc, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_shamt, ex_dest;
  logic [3:0]  ex_alu_op;
  logic        ex_alu_src_imm, ex_reg_write, ex_mem_read, ex_mem_write, ex_link;

  decode_stage dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .instruction_in(instruction_in),
    .rf_rs_addr(rf_rs_addr), .rf_rt_addr(rf_rt_addr),
    .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data),
    .ex_fwd_reg_write(ex_fwd_reg_write), .ex_fwd_mem_read(ex_fwd_mem_read),
    .ex_fwd_dest(ex_fwd_dest), .mem_fwd_reg_write(mem_fwd_reg_write),
    .mem_fwd_mem_read(mem_fwd_mem_read), .mem_fwd_dest(mem_fwd_dest),
    .mem_fwd_result(mem_fwd_result), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .illegal(illegal), .ex_pc(ex_pc),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_shamt(ex_shamt), .ex_dest(ex_dest), .ex_alu_op(ex_alu_op),
    .ex_alu_src_imm(ex_alu_src_imm), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_link(ex_link)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, rs_d, rt_d;
    logic [4:0]  dest;
    logic [3:0]  op;
    logic        src, rw, mr, mw, link;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Expected ID/EX entry for the current decode cycle; operands come from
  // whatever the bench is driving as regfile data (zero while in reset).
  task automatic expect_ex(input logic [31:0] pc, input logic [4:0] dest,
                           input logic [3:0] op, input logic src, input logic rw,
                           input logic mr, input logic mw, input logic link);
    exp_t e;
    e.pc = pc; e.dest = dest; e.op = op; e.src = src; e.rw = rw;
    e.mr = mr; e.mw = mw; e.link = link;
    e.rs_d = rst ? 32'h0 : rf_rs_data;
    e.rt_d = rst ? 32'h0 : rf_rt_data;
    sb.push_back(e);
  endtask

  task automatic expect_bubble(input logic [31:0] pc);
    expect_ex(pc, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step();
    exp_t e;
    check("sb_depth", 32'(sb.size()), 32'd1);
    @(posedge clk); #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("ex_pc", ex_pc, e.pc);
      check("ex_rs_data", ex_rs_data, e.rs_d);
      check("ex_rt_data", ex_rt_data, e.rt_d);
      check("ex_dest", 32'(ex_dest), 32'(e.dest));
      check("ex_alu_op", 32'(ex_alu_op), 32'(e.op));
      check("ex_alu_src_imm", 32'(ex_alu_src_imm), 32'(e.src));
      check("ex_reg_write", 32'(ex_reg_write), 32'(e.rw));
      check("ex_mem_read", 32'(ex_mem_read), 32'(e.mr));
      check("ex_mem_write", 32'(ex_mem_write), 32'(e.mw));
      check("ex_link", 32'(ex_link), 32'(e.link));
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] instr,
                       input logic [31:0] rs_d, input logic [31:0] rt_d);
    pc_in = pc; instruction_in = instr; rf_rs_data = rs_d; rf_rt_data = rt_d;
  endtask

  task automatic clr_fwd();
    ex_fwd_reg_write = 1'b0; ex_fwd_mem_read = 1'b0; ex_fwd_dest = 5'd0;
    mem_fwd_reg_write = 1'b0; mem_fwd_mem_read = 1'b0; mem_fwd_dest = 5'd0;
    mem_fwd_result = 32'h0;
  endtask

  task automatic check_ctl(input string tag, input logic s, input logic bt,
                           input logic [31:0] tgt, input logic ill);
    #1;
    check({tag, "_stall"}, 32'(stall), 32'(s));
    check({tag, "_taken"}, 32'(branch_taken), 32'(bt));
    check({tag, "_target"}, branch_target, tgt);
    check({tag, "_illegal"}, 32'(illegal), 32'(ill));
  endtask

  initial begin
    rst = 1'b1;
    clr_fwd();
    drive(32'h0, 32'h012A4020, 32'h0000_0009, 32'h0000_000A);  // ADD r8,r9,r10

    // Reset held for two clocks
    check_ctl("rst", 1'b0, 1'b0, 32'h0, 1'b0);
    check("rst_rs_addr", 32'(rf_rs_addr), 32'd9);
    check("rst_rt_addr", 32'(rf_rt_addr), 32'd10);
    expect_bubble(32'h0); step();
    expect_bubble(32'h0); step();
    rst = 1'b0;
    check_ctl("add", 1'b0, 1'b0, 32'h0, 1'b0);
    expect_ex(32'h0, 5'd8, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();

    // Load-use: LW r2 in EX, ADD r3,r2,r4 in decode
    ex_fwd_reg_write = 1'b1; ex_fwd_mem_read = 1'b1; ex_fwd_dest = 5'd2;
    drive(32'h8, 32'h00441820, 32'h1111_1111, 32'h2222_2222);
    check_ctl("lu_stall", 1'b1, 1'b0, 32'h0, 1'b0);
    expect_bubble(32'h8); step();
    clr_fwd();
    mem_fwd_reg_write = 1'b1; mem_fwd_mem_read = 1'b1; mem_fwd_dest = 5'd2;
    drive(32'hC, 32'h0, 32'h3333_3333, 32'h4444_4444);
    check_ctl("lu_replay", 1'b0, 1'b0, 32'h0, 1'b0);
    expect_ex(32'h8, 5'd3, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();

    // BEQ r2,r0,+4 at 0x40 right behind LW r2: two stall cycles
    clr_fwd();
    ex_fwd_reg_write = 1'b1; ex_fwd_mem_read = 1'b1; ex_fwd_dest = 5'd2;
    drive(32'h40, 32'h10400004, 32'h5, 32'h0);
    check_ctl("beq_s1", 1'b1, 1'b0, 32'h0, 1'b0);
    expect_bubble(32'h40); step();
    clr_fwd();
    mem_fwd_reg_write = 1'b1; mem_fwd_mem_read = 1'b1; mem_fwd_dest = 5'd2;
    drive(32'h44, 32'h0, 32'h5, 32'h0);
    check_ctl("beq_s2", 1'b1, 1'b0, 32'h0, 1'b0);
    expect_bubble(32'h40); step();
    clr_fwd();
    drive(32'h44, 32'h0, 32'h0, 32'h0);
    check_ctl("beq_go", 1'b0, 1'b1, 32'h54, 1'b0);
    expect_bubble(32'h40); step();

    // BNE r5,r0,-1 at 0x100 with r5 forwarded from MEM
    mem_fwd_reg_write = 1'b1; mem_fwd_dest = 5'd5; mem_fwd_result = 32'd7;
    drive(32'h100, 32'h14A0FFFF, 32'h0, 32'h0);
    check_ctl("bne", 1'b0, 1'b1, 32'h100, 1'b0);
    expect_bubble(32'h100); step();
    clr_fwd();

    // JAL 0x00100 at 0x1000
    drive(32'h1000, 32'h0C000100, 32'h0, 32'h0);
    check_ctl("jal", 1'b0, 1'b1, 32'h400, 1'b0);
    expect_ex(32'h1000, 5'd31, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step();

    // JR r9 with r9 from the regfile
    drive(32'h1004, 32'h01200008, 32'h0000_2000, 32'h0);
    check_ctl("jr", 1'b0, 1'b1, 32'h2000, 1'b0);
    expect_bubble(32'h1004); step();

    // Unsupported opcode 0x3F
    drive(32'h2000, 32'hFC000000, 32'h0, 32'h0);
    check_ctl("ill", 1'b0, 1'b0, 32'h0, 1'b1);
    expect_bubble(32'h2000); step();

    // ORI r1,r0,0xFFFF zero-extends
    drive(32'h2004, 32'h3401FFFF, 32'h0, 32'h0);
    check_ctl("ori", 1'b0, 1'b0, 32'h0, 1'b0);
    expect_ex(32'h2004, 5'd1, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    check("ori_imm", ex_imm, 32'h0000_FFFF);

    // ADDI r2,r0,0xFFFF sign-extends
    drive(32'h2008, 32'h2002FFFF, 32'h0, 32'h0);
    expect_ex(32'h2008, 5'd2, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    check("addi_imm", ex_imm, 32'hFFFF_FFFF);

    // SW r4,8(r1) and LW r5,4(r1)
    drive(32'h200C, 32'hAC240008, 32'h0000_0100, 32'hDEAD_BEEF);
    expect_ex(32'h200C, 5'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    drive(32'h2010, 32'h8C250004, 32'h0000_0100, 32'h0);
    expect_ex(32'h2010, 5'd5, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step();

    // SLL r6,r7,3: shift op and shamt
    drive(32'h2014, 32'h000730C0, 32'h0, 32'h0000_0007);
    expect_ex(32'h2014, 5'd6, 4'd8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    check("sll_shamt", 32'(ex_shamt), 32'd3);

    // Reset during a load-use stall drops the held instruction
    ex_fwd_reg_write = 1'b1; ex_fwd_mem_read = 1'b1; ex_fwd_dest = 5'd2;
    drive(32'h8, 32'h00441820, 32'h1, 32'h2);
    check_ctl("mid_stall", 1'b1, 1'b0, 32'h0, 1'b0);
    rst = 1'b1;
    check_ctl("mid_rst", 1'b0, 1'b0, 32'h0, 1'b0);
    expect_bubble(32'h0); step();
    rst = 1'b0;
    clr_fwd();
    drive(32'h200, 32'h0, 32'h0, 32'h0);
    check_ctl("post_rst", 1'b0, 1'b0, 32'h0, 1'b0);
    expect_ex(32'h200, 5'd0, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
